alu_mdu: RTL and testbench

//  Parametrised execute-stage ALU plus multi-cycle multiply/divide unit (MDU) with HI/LO registers.
//  ALU ops are combinational, result same cycle. MULT/DIV ops run for a fixed latency under a start/busy handshake.

---
 rtl/alu_pkg.sv | 50 +++++
 rtl/mdu_core.sv | 111 +++++++++++
 rtl/alu_mdu.sv | 69 ++++++
 tb/tb_alu_mdu.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the execute-stage ALU and the multiply/divide unit.
// MDU op codes form their own space and are only decoded while start is high.
package alu_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_LUI  = 4'd7;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;
    localparam logic [3:0] ALU_SRA  = 4'd10;
    localparam logic [3:0] ALU_MFHI = 4'd11;
    localparam logic [3:0] ALU_MFLO = 4'd12;

    localparam logic [3:0] MDU_MULT  = 4'd0;
    localparam logic [3:0] MDU_MULTU = 4'd1;
    localparam logic [3:0] MDU_DIV   = 4'd2;
    localparam logic [3:0] MDU_DIVU  = 4'd3;
    localparam logic [3:0] MDU_MADD  = 4'd4;
    localparam logic [3:0] MDU_MADDU = 4'd5;
    localparam logic [3:0] MDU_MSUB  = 4'd6;
    localparam logic [3:0] MDU_MSUBU = 4'd7;
    localparam logic [3:0] MDU_MTHI  = 4'd11;
    localparam logic [3:0] MDU_MTLO  = 4'd12;

    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_BUSY = 1'b1
    } mdu_state_e;

    // Multi-cycle ops that occupy the unit; MTHI/MTLO complete at issue.
    function automatic logic is_mdu_op(input logic [3:0] op);
`ifdef MDU_MADD_EN
        return (op <= MDU_MSUBU);
`else
        return (op <= MDU_DIVU);
`endif
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_core.sv
// Multi-cycle multiply/divide engine with HI/LO; MADD family enabled by MDU_MADD_EN.
// Operands are captured at issue and the result is written once the counter expires.
module mdu_core
    import alu_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             flush_i,
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 1);

    mdu_state_e        state_q;
    logic [CW-1:0]     cnt_q;
    logic [3:0]        op_q;
    logic [WIDTH-1:0]  a_q, b_q, hi_q, lo_q;
    logic [2*WIDTH-1:0] hiLo_d, prodSigned, prodUnsigned;
    logic [WIDTH-1:0]  divisorS, divisorU, quotS, remS, quotU, remU;
    logic              divOverflow;

    assign prodSigned   = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
    assign prodUnsigned = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};

    // MIN / -1 is divided by 1 instead, which yields quotient MIN and remainder 0.
    assign divOverflow = (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (&b_q);
    assign divisorS    = ((b_q == '0) || divOverflow) ? WIDTH'(1) : b_q;
    assign divisorU    = (b_q == '0) ? WIDTH'(1) : b_q;
    assign quotS       = $signed(a_q) / $signed(divisorS);
    assign remS        = $signed(a_q) % $signed(divisorS);
    assign quotU       = a_q / divisorU;
    assign remU        = a_q % divisorU;

    always_comb begin
        hiLo_d = {hi_q, lo_q};
        case (op_q)
            MDU_MULT:  hiLo_d = prodSigned;
            MDU_MULTU: hiLo_d = prodUnsigned;
            MDU_DIV:   hiLo_d = (b_q == '0) ? {a_q, {WIDTH{1'b1}}} : {remS, quotS};
            MDU_DIVU:  hiLo_d = (b_q == '0) ? {a_q, {WIDTH{1'b1}}} : {remU, quotU};
`ifdef MDU_MADD_EN
            MDU_MADD:  hiLo_d = {hi_q, lo_q} + prodSigned;
            MDU_MADDU: hiLo_d = {hi_q, lo_q} + prodUnsigned;
            MDU_MSUB:  hiLo_d = {hi_q, lo_q} - prodSigned;
            MDU_MSUBU: hiLo_d = {hi_q, lo_q} - prodUnsigned;
`endif
            default:   hiLo_d = {hi_q, lo_q};
        endcase
    end

    // Flush outranks both completion and a fresh issue; starts while busy are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MDU_IDLE;
            cnt_q   <= '0;
            op_q    <= MDU_MULT;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else if (flush_i) begin
            state_q <= MDU_IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                MDU_IDLE: begin
                    if (start_i) begin
                        if (is_mdu_op(op_i)) begin
                            op_q    <= op_i;
                            a_q     <= a_i;
                            b_q     <= b_i;
                            cnt_q   <= is_div_op(op_i) ? DIV_LOAD : MUL_LOAD;
                            state_q <= MDU_BUSY;
                        end else if (op_i == MDU_MTHI) begin
                            hi_q <= a_i;
                        end else if (op_i == MDU_MTLO) begin
                            lo_q <= a_i;
                        end
                    end
                end
                MDU_BUSY: begin
                    if (cnt_q == '0) begin
                        {hi_q, lo_q} <= hiLo_d;
                        state_q      <= MDU_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= MDU_IDLE;
            endcase
        end
    end

    assign busy_o = (state_q == MDU_BUSY);
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: rtl/alu_mdu.sv
// Execute-stage ALU with an attached multiply/divide unit (MADD family via MDU_MADD_EN).
// ALU results are purely combinational; MFHI/MFLO expose the current HI/LO.
module alu_mdu
    import alu_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             start,
    input  logic             flush,
    output logic [WIDTH-1:0] c,
    output logic             zero,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int SH = $clog2(WIDTH);

    logic [SH-1:0] shamt;

    assign shamt = a[SH-1:0];

    always_comb begin
        c = '0;
        case (op)
            ALU_ADD:  c = a + b;
            ALU_SUB:  c = a - b;
            ALU_AND:  c = a & b;
            ALU_OR:   c = a | b;
            ALU_XOR:  c = a ^ b;
            ALU_SLT:  c = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: c = {{(WIDTH-1){1'b0}}, (a < b)};
            ALU_LUI:  c = b << (WIDTH / 2);
            ALU_SLL:  c = b << shamt;
            ALU_SRL:  c = b >> shamt;
            ALU_SRA:  c = $unsigned($signed(b) >>> shamt);
            ALU_MFHI: c = hi;
            ALU_MFLO: c = lo;
            default:  c = '0;
        endcase
    end

    assign zero = (c == '0);

    mdu_core #(
        .WIDTH      (WIDTH),
        .MUL_CYCLES (MUL_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_mdu_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start),
        .flush_i (flush),
        .op_i    (op),
        .a_i     (a),
        .b_i     (b),
        .busy_o  (busy),
        .hi_o    (hi),
        .lo_o    (lo)
    );

endmodule

// File: tb/tb_alu_mdu.sv
// Bench for alu_mdu at WIDTH=32 and WIDTH=16 side by side, checked against an arithmetic model.
// The 16-bit unit sees the sign bit plus low 15 bits of each 32-bit operand.
module tb_alu_mdu;
    import alu_pkg::*;

    localparam int MUL_N = 5;
    localparam int DIV_N = 10;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  op    = ALU_ADD;
    logic [31:0] a     = '0;
    logic [31:0] b     = '0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] a16, b16;

    logic [31:0] c32, hi32, lo32;
    logic        zero32, busy32;
    logic [15:0] c16, hi16, lo16;
    logic        zero16, busy16;

    int checks = 0;
    int errors = 0;

    logic [63:0] mHi [2];
    logic [63:0] mLo [2];
    int          mRemain [2];
    logic [3:0]  mOp [2];
    logic [63:0] mA [2];
    logic [63:0] mB [2];

    assign a16 = {a[31], a[14:0]};
    assign b16 = {b[31], b[14:0]};

    always #5 clk = ~clk;

    alu_mdu #(.WIDTH(32), .MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut32 (
        .clk(clk), .rst_n(rst_n), .op(op), .a(a), .b(b), .start(start), .flush(flush),
        .c(c32), .zero(zero32), .busy(busy32), .hi(hi32), .lo(lo32)
    );

    alu_mdu #(.WIDTH(16), .MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut16 (
        .clk(clk), .rst_n(rst_n), .op(op), .a(a16), .b(b16), .start(start), .flush(flush),
        .c(c16), .zero(zero16), .busy(busy16), .hi(hi16), .lo(lo16)
    );

    function automatic logic [63:0] maskW(input int w);
        return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    endfunction

    function automatic longint sx(input logic [63:0] v, input int w);
        if (v[w-1]) return longint'(v | ~maskW(w));
        return longint'(v);
    endfunction

    function automatic logic isLongOp(input logic [3:0] o);
`ifdef MDU_MADD_EN
        return o inside {MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU,
                         MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU};
`else
        return o inside {MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU};
`endif
    endfunction

    function automatic logic [63:0] aluModel(input int w, input logic [3:0] o,
                                             input logic [63:0] x, input logic [63:0] y,
                                             input logic [63:0] hiV, input logic [63:0] loV);
        logic [63:0] m;
        int sh;
        longint r;
        m  = maskW(w);
        sh = int'(x % 64'(w));
        case (o)
            ALU_ADD:  return (x + y) & m;
            ALU_SUB:  return (x - y) & m;
            ALU_AND:  return x & y;
            ALU_OR:   return x | y;
            ALU_XOR:  return x ^ y;
            ALU_SLT:  return (sx(x, w) < sx(y, w)) ? 64'd1 : 64'd0;
            ALU_SLTU: return (x < y) ? 64'd1 : 64'd0;
            ALU_LUI:  return (y << (w / 2)) & m;
            ALU_SLL:  return (y << sh) & m;
            ALU_SRL:  return y >> sh;
            ALU_SRA: begin
                r = sx(y, w) >>> sh;
                return 64'(r) & m;
            end
            ALU_MFHI: return hiV;
            ALU_MFLO: return loV;
            default:  return 64'd0;
        endcase
    endfunction

    // Returns {hi, lo}, each in a 64-bit slot.
    function automatic logic [127:0] mduModel(input int w, input logic [3:0] o,
                                              input logic [63:0] x, input logic [63:0] y,
                                              input logic [63:0] hiV, input logic [63:0] loV);
        logic [63:0] m, acc, q, r, ps, pu;
        m   = maskW(w);
        acc = (hiV << w) | loV;
        ps  = 64'(sx(x, w) * sx(y, w));
        pu  = x * y;
        q   = '0;
        r   = '0;
        case (o)
            MDU_MULT:  acc = ps;
            MDU_MULTU: acc = pu;
            MDU_DIV, MDU_DIVU: begin
                if (y == 0) begin
                    q = m;
                    r = x;
                end else if (o == MDU_DIV) begin
                    q = 64'(sx(x, w) / sx(y, w));
                    r = 64'(sx(x, w) % sx(y, w));
                end else begin
                    q = x / y;
                    r = x % y;
                end
                acc = ((r & m) << w) | (q & m);
            end
            MDU_MADD:  acc = acc + ps;
            MDU_MADDU: acc = acc + pu;
            MDU_MSUB:  acc = acc - ps;
            MDU_MSUBU: acc = acc - pu;
            default:   acc = acc;
        endcase
        return {((acc >> w) & m), (acc & m)};
    endfunction

    function automatic logic [63:0] opA(input int k);
        return (k == 0) ? {32'd0, a} : {48'd0, a16};
    endfunction

    function automatic logic [63:0] opB(input int k);
        return (k == 0) ? {32'd0, b} : {48'd0, b16};
    endfunction

    // Model: a result is computed when its latency runs out; busy is "cycles remaining > 0".
    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                mHi[k]     = '0;
                mLo[k]     = '0;
                mRemain[k] = 0;
            end else if (flush) begin
                mRemain[k] = 0;
            end else if (mRemain[k] > 0) begin
                mRemain[k]--;
                if (mRemain[k] == 0)
                    {mHi[k], mLo[k]} = mduModel((k == 0) ? 32 : 16, mOp[k], mA[k], mB[k],
                                                mHi[k], mLo[k]);
            end else if (start) begin
                if (isLongOp(op)) begin
                    mOp[k]     = op;
                    mA[k]      = opA(k);
                    mB[k]      = opB(k);
                    mRemain[k] = (op == MDU_DIV || op == MDU_DIVU) ? DIV_N : MUL_N;
                end else if (op == MDU_MTHI) begin
                    mHi[k] = opA(k);
                end else if (op == MDU_MTLO) begin
                    mLo[k] = opA(k);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkAll();
        logic [63:0] e32, e16;
        e32 = aluModel(32, op, opA(0), opB(0), mHi[0], mLo[0]);
        e16 = aluModel(16, op, opA(1), opB(1), mHi[1], mLo[1]);
        checkOutput("c32",    64'(c32),    e32);
        checkOutput("zero32", 64'(zero32), 64'(e32 == 0));
        checkOutput("busy32", 64'(busy32), 64'(mRemain[0] > 0));
        checkOutput("hi32",   64'(hi32),   mHi[0]);
        checkOutput("lo32",   64'(lo32),   mLo[0]);
        checkOutput("c16",    64'(c16),    e16);
        checkOutput("zero16", 64'(zero16), 64'(e16 == 0));
        checkOutput("busy16", 64'(busy16), 64'(mRemain[1] > 0));
        checkOutput("hi16",   64'(hi16),   mHi[1]);
        checkOutput("lo16",   64'(lo16),   mLo[1]);
    endtask

    always @(posedge clk) begin
        #3;
        checkAll();
    end

    task automatic applyStimulus(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                 input logic s, input logic f);
        @(negedge clk);
        op    = o;
        a     = x;
        b     = y;
        start = s;
        flush = f;
    endtask

    task automatic waitIdle(output int cyc);
        cyc = 0;
        for (int i = 0; i < 200 && busy32; i++) begin
            cyc++;
            @(negedge clk);
        end
        if (busy32) begin
            checks++;
            errors++;
            $display("[TB] FAIL wait_idle: busy=%0b after 200 cycles, expected 0", busy32);
        end
    endtask

    task automatic runMdu(input string name, input logic [3:0] o, input logic [31:0] x,
                          input logic [31:0] y);
        int cyc;
        applyStimulus(o, x, y, 1'b1, 1'b0);
        applyStimulus(ALU_MFHI, x, y, 1'b0, 1'b0);
        waitIdle(cyc);
        checkOutput({name, "_cycles"}, 64'(cyc),
                    64'((o == MDU_DIV || o == MDU_DIVU) ? DIV_N : MUL_N));
    endtask

    logic [3:0]  tOp [9] = '{ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLTU,
                             ALU_LUI, ALU_SLL, ALU_SRL, 4'd13};
    logic [31:0] tA  [9] = '{32'hF0F0_1234, 32'hF0F0_1234, 32'hF0F0_1234, 32'hFFFF_FFFF,
                             32'hFFFF_FFFF, 32'h0, 32'd35, 32'd4, 32'h1234_5678};
    logic [31:0] tB  [9] = '{32'h0FF0_FFFF, 32'h0FF0_FFFF, 32'h0FF0_FFFF, 32'h1, 32'h1,
                             32'h1234, 32'h1, 32'h8000_0000, 32'h9ABC_DEF0};

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [127:0] mm;

        // Pin the model to hand-computed values before trusting it.
        checkOutput("model_sra", aluModel(32, ALU_SRA, 64'd4, 64'h8000_0000, 0, 0), 64'hF800_0000);
        mm = mduModel(32, MDU_DIV, 64'hFFFF_FFF9, 64'd2, 0, 0);
        checkOutput("model_div_lo", mm[63:0],   64'hFFFF_FFFD);
        checkOutput("model_div_hi", mm[127:64], 64'hFFFF_FFFF);
        mm = mduModel(16, MDU_MULT, 64'hFFFD, 64'd7, 0, 0);
        checkOutput("model_mult16_lo", mm[63:0], 64'hFFEB);

        #2;
        checkOutput("rst_busy32", 64'(busy32), 64'd0);
        checkOutput("rst_hi32",   64'(hi32),   64'd0);
        checkOutput("rst_lo32",   64'(lo32),   64'd0);
        checkOutput("rst_busy16", 64'(busy16), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(ALU_ADD, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
        #1;
        checkOutput("add_c32",    64'(c32),    64'h8000_0000);
        checkOutput("add_zero32", 64'(zero32), 64'd0);
        checkOutput("add_c16",    64'(c16),    64'h8000);
        applyStimulus(ALU_SUB, 32'd5, 32'd5, 1'b0, 1'b0);
        #1;
        checkOutput("sub_c32",    64'(c32),    64'd0);
        checkOutput("sub_zero32", 64'(zero32), 64'd1);
        checkOutput("sub_zero16", 64'(zero16), 64'd1);
        applyStimulus(ALU_SRA, 32'd4, 32'h8000_0000, 1'b0, 1'b0);
        #1;
        checkOutput("sra_c32", 64'(c32), 64'hF800_0000);
        checkOutput("sra_c16", 64'(c16), 64'hF800);

        for (int i = 0; i < 9; i++)
            applyStimulus(tOp[i], tA[i], tB[i], 1'b0, 1'b0);

        runMdu("mult", MDU_MULT, 32'hFFFF_FFFD, 32'd7);
        checkOutput("mult_hi32", 64'(hi32), 64'hFFFF_FFFF);
        checkOutput("mult_lo32", 64'(lo32), 64'hFFFF_FFEB);
        checkOutput("mult_lo16", 64'(lo16), 64'hFFEB);

        runMdu("div", MDU_DIV, 32'hFFFF_FFF9, 32'd2);
        checkOutput("div_lo32", 64'(lo32), 64'hFFFF_FFFD);
        checkOutput("div_hi32", 64'(hi32), 64'hFFFF_FFFF);
        checkOutput("div_lo16", 64'(lo16), 64'hFFFD);

        runMdu("divovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        checkOutput("divovf_lo32", 64'(lo32), 64'h8000_0000);
        checkOutput("divovf_hi32", 64'(hi32), 64'd0);
        checkOutput("divovf_lo16", 64'(lo16), 64'h8000);

        runMdu("divu0", MDU_DIVU, 32'd9, 32'd0);
        checkOutput("divu0_lo32", 64'(lo32), 64'hFFFF_FFFF);
        checkOutput("divu0_hi32", 64'(hi32), 64'd9);
        checkOutput("divu0_hi16", 64'(hi16), 64'd9);

        // MULTU aborted on its third cycle; a second start while busy must vanish.
        applyStimulus(MDU_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b1, 1'b0);
        applyStimulus(MDU_DIV, 32'd100, 32'd3, 1'b1, 1'b0);
        applyStimulus(ALU_MFLO, 32'd5, 32'd6, 1'b0, 1'b0);
        applyStimulus(ALU_MFLO, 32'd5, 32'd6, 1'b0, 1'b1);
        applyStimulus(ALU_MFLO, 32'd5, 32'd6, 1'b0, 1'b0);
        #1;
        checkOutput("flush_busy32", 64'(busy32), 64'd0);
        checkOutput("flush_hi32",   64'(hi32),   64'd9);
        checkOutput("flush_lo32",   64'(lo32),   64'hFFFF_FFFF);
        checkOutput("flush_busy16", 64'(busy16), 64'd0);
        repeat (12) applyStimulus(ALU_MFLO, 32'd5, 32'd6, 1'b0, 1'b0);
        checkOutput("flush_lo32_later", 64'(lo32), 64'hFFFF_FFFF);

        // Operands change right after issue; the result must use the latched ones.
        applyStimulus(MDU_MULTU, 32'h0001_0000, 32'h0001_0000, 1'b1, 1'b0);
        applyStimulus(ALU_MFHI, 32'd3, 32'd3, 1'b0, 1'b0);
        begin
            int cyc;
            waitIdle(cyc);
            checkOutput("latch_cycles", 64'(cyc), 64'(MUL_N));
        end
        checkOutput("latch_hi32", 64'(hi32), 64'd1);
        checkOutput("latch_lo32", 64'(lo32), 64'd0);

        applyStimulus(MDU_DIV, 32'd100, 32'd7, 1'b1, 1'b0);
        applyStimulus(ALU_ADD, 32'd100, 32'd7, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("div_busy_pre_rst", 64'(busy32), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_busy32", 64'(busy32), 64'd0);
        checkOutput("rst_mid_hi32",   64'(hi32),   64'd0);
        checkOutput("rst_mid_lo32",   64'(lo32),   64'd0);
        checkOutput("rst_mid_busy16", 64'(busy16), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(MDU_MTLO, 32'h1234, 32'd0, 1'b1, 1'b0);
        applyStimulus(ALU_MFLO, 32'h1234, 32'd0, 1'b0, 1'b0);
        #1;
        checkOutput("mtlo_lo32",   64'(lo32),   64'h1234);
        checkOutput("mtlo_c32",    64'(c32),    64'h1234);
        checkOutput("mtlo_busy32", 64'(busy32), 64'd0);
        checkOutput("mtlo_lo16",   64'(lo16),   64'h1234);

`ifdef MDU_MADD_EN
        applyStimulus(MDU_MTLO, 32'd10, 32'd0, 1'b1, 1'b0);
        applyStimulus(MDU_MTHI, 32'd0, 32'd0, 1'b1, 1'b0);
        runMdu("madd", MDU_MADD, 32'd2, 32'd3);
        checkOutput("madd_lo32", 64'(lo32), 64'd16);
        checkOutput("madd_hi32", 64'(hi32), 64'd0);
        checkOutput("madd_lo16", 64'(lo16), 64'd16);
`else
        applyStimulus(MDU_MADD, 32'd2, 32'd3, 1'b1, 1'b0);
        applyStimulus(ALU_MFLO, 32'd2, 32'd3, 1'b0, 1'b0);
        #1;
        checkOutput("madd_off_busy32", 64'(busy32), 64'd0);
        checkOutput("madd_off_lo32",   64'(lo32),   64'h1234);
`endif

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
